// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment display datapath: digit count,
// active-low anode codes and the anode scan FSM state type.
package seg_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_e;

  // Active-low one-hot select for a digit index; never returns AN_OFF.
  function automatic logic [3:0] sel_code(input logic [1:0] idx);
    logic [3:0] code;
    unique case (idx)
      2'd0:    code = AN_D0;
      2'd1:    code = AN_D1;
      2'd2:    code = AN_D2;
      default: code = AN_D3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Per-digit dwell counter: counts 0..DWELL-1 and flags the last blank cycle
// and the last cycle of the dwell.
module scan_dwell_counter #(
  parameter int unsigned DWELL        = 10,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       inc,
  output logic [$clog2(DWELL)-1:0]   cnt,
  output logic                       at_blank_end,
  output logic                       at_dwell_end
);

  localparam int unsigned CntW = $clog2(DWELL);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign cnt          = cnt_q;
  assign at_blank_end = (cnt_q == CntW'(BLANK_CYCLES - 1));
  assign at_dwell_end = (cnt_q == CntW'(DWELL - 1));

  // Next count: clear wins, otherwise wrap at the end of the dwell.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_dwell_end ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/anode_scan_ctrl.sv
// Four-digit anode scan controller: rotates an active-low digit select and
// drives the anodes with a blanking interval at the start of every dwell.
module anode_scan_ctrl
  import seg_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] digit_en,
  output logic [3:0] digit_sel,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       scan_tick
);

  localparam int unsigned DWELL = CLK_HZ / REFRESH_HZ;
  localparam int unsigned CntW  = $clog2(DWELL);

  if (DWELL < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL) begin : g_bad_params
    $error("anode_scan_ctrl: need DWELL >= 2 and 1 <= BLANK_CYCLES < DWELL");
  end

  scan_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  an_q, an_d;
  logic        tick_q, tick_d;

  logic            cnt_clr, cnt_inc;
  logic            at_blank_end, at_dwell_end;
  // Raw count is not needed here; only the decoded dwell boundaries are.
  logic [CntW-1:0] cnt_unused;

  scan_dwell_counter #(
    .DWELL        (DWELL),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_dwell_cnt (
    .clk          (clk),
    .reset        (reset),
    .clr          (cnt_clr),
    .inc          (cnt_inc),
    .cnt          (cnt_unused),
    .at_blank_end (at_blank_end),
    .at_dwell_end (at_dwell_end)
  );

  assign digit_sel = sel_q;
  assign an        = an_q;
  assign digit_idx = idx_q;
  assign scan_tick = tick_q;

  // Next state, index and registered outputs; an is derived from the next
  // state so it always matches the select registered alongside it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (en) state_d = BLANK;
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          if (at_blank_end) state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!en) begin
          // Dropping en never advances the digit, even on the last cycle.
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          if (at_dwell_end) begin
            state_d = BLANK;
            idx_d   = idx_q + 2'd1;
            tick_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    sel_d = sel_code(idx_d);
    an_d  = (state_d == DRIVE && digit_en[idx_d]) ? sel_d : AN_OFF;
  end

  // State and output registers. Reset parks in BLANK with cnt=0: with en low
  // the first edge moves to IDLE, and both states look identical on the
  // outputs, so this matches "BLANK if en else IDLE" without an async load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BLANK;
      idx_q   <= 2'd0;
      sel_q   <= AN_D0;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Scoreboard bench for anode_scan_ctrl with DWELL=10, BLANK_CYCLES=2.
module tb_anode_scan_ctrl;

  localparam int DWELL = 10;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] digit_en;
  logic [3:0] digit_sel;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       scan_tick;

  anode_scan_ctrl #(
    .CLK_HZ       (100),
    .REFRESH_HZ   (10),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .en        (en),
    .digit_en  (digit_en),
    .digit_sel (digit_sel),
    .an        (an),
    .digit_idx (digit_idx),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] sel;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within the dwell, running flag, digit index.
  int         m_pos  = 0;
  bit         m_run  = 1'b1;
  logic [1:0] m_idx  = 2'd0;
  logic       m_tick = 1'b0;

  always @(posedge clk) begin
    exp_t       e;
    logic [3:0] s;
    if (rst) begin
      m_run = 1'b1; m_pos = 0; m_idx = 2'd0; m_tick = 1'b0;
    end else if (!en) begin
      m_run = 1'b0; m_pos = 0; m_tick = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_pos = 0; m_tick = 1'b0;
    end else if (m_pos == DWELL - 1) begin
      m_pos = 0; m_idx = m_idx + 2'd1; m_tick = 1'b1;
    end else begin
      m_pos = m_pos + 1; m_tick = 1'b0;
    end
    s      = 4'hF ^ (4'h1 << m_idx);
    e.sel  = s;
    e.idx  = m_idx;
    e.tick = m_tick;
    e.an   = (!rst && m_run && m_pos >= BLANK && digit_en[m_idx]) ? s : 4'hF;
    sb_q.push_back(e);
  end

  logic [3:0] prev_sel = 4'hE;

  // Pop and compare once per cycle, plus select/anode invariants.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("sb_an", an, e.an);
      check_eq("sb_sel", digit_sel, e.sel);
      check_eq("sb_idx", digit_idx, e.idx);
      check_eq("sb_tick", scan_tick, e.tick);
    end
    check_eq("sel_onehot", $countones(~digit_sel), 1);
    if (digit_sel !== prev_sel) check_eq("an_off_on_sel_change", an, 4'hF);
    prev_sel = digit_sel;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset for a few cycles and release on a falling edge (cycle 0 starts).
  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  // Timing after release with en=1 and digit_en=1111.
  task automatic s1_checks();
    step(1);  check_eq("s1_c1_an", an, 4'hF);
    step(1);  check_eq("s1_c2_an", an, 4'hE);
    step(7);  check_eq("s1_c9_an", an, 4'hE);
    step(1);
    check_eq("s1_c10_sel", digit_sel, 4'hD);
    check_eq("s1_c10_idx", digit_idx, 2'd1);
    check_eq("s1_c10_an", an, 4'hF);
    check_eq("s1_c10_tick", scan_tick, 1'b1);
    step(1);  check_eq("s1_c11_tick", scan_tick, 1'b0);
    step(1);  check_eq("s1_c12_an", an, 4'hD);
    step(7);  check_eq("s1_c19_an", an, 4'hD);
  endtask

  initial begin
    int ticks, on_e, on_b, on_other, bad_an, bad_sel;
    rst = 1'b1; en = 1'b1; digit_en = 4'hF;

    // Scenarios 1 and 2: first dwell timing and a full wrap.
    do_reset();
    s1_checks();
    step(1);  check_eq("s2_c20_sel", digit_sel, 4'hB);
    step(10); check_eq("s2_c30_sel", digit_sel, 4'h7);
    step(10);
    check_eq("s2_c40_sel", digit_sel, 4'hE);
    check_eq("s2_c40_tick", scan_tick, 1'b1);

    // Scenario 5: async reset mid-drive of digit 2 (cycle 65).
    step(25);
    check_eq("s5_pre_an", an, 4'hB);
    #2 rst = 1'b1;
    #1;
    check_eq("s5_async_an", an, 4'hF);
    check_eq("s5_async_sel", digit_sel, 4'hE);
    check_eq("s5_async_idx", digit_idx, 2'd0);
    step(3);
    rst = 1'b0;
    s1_checks();

    // Scenario 4: drop en on the last cycle of digit 1, re-raise later.
    en = 1'b0;
    step(1);
    check_eq("s4_idle_idx", digit_idx, 2'd1);
    check_eq("s4_idle_tick", scan_tick, 1'b0);
    check_eq("s4_idle_an", an, 4'hF);
    step(4);
    en = 1'b1;
    step(1);  check_eq("s4_blank0_an", an, 4'hF);
    step(1);  check_eq("s4_blank1_an", an, 4'hF);
    step(1);  check_eq("s4_drive_first_an", an, 4'hD);
    step(7);  check_eq("s4_drive_last_an", an, 4'hD);
    step(1);
    check_eq("s4_adv_tick", scan_tick, 1'b1);
    check_eq("s4_adv_sel", digit_sel, 4'hB);

    // Scenario 3: digit mask 0101 over one frame.
    digit_en = 4'h5;
    do_reset();
    ticks = 0; on_e = 0; on_b = 0; on_other = 0;
    for (int c = 1; c <= 4 * DWELL; c++) begin
      step(1);
      if (scan_tick) ticks++;
      if (an == 4'hE) on_e++;
      else if (an == 4'hB) on_b++;
      else if (an != 4'hF) on_other++;
    end
    check_eq("s3_ticks", ticks, 4);
    check_eq("s3_d0_on", on_e, DWELL - BLANK);
    check_eq("s3_d2_on", on_b, DWELL - BLANK);
    check_eq("s3_other_on", on_other, 0);

    // Scenario 6: en low from reset for 100 cycles.
    en = 1'b0;
    digit_en = 4'hF;
    do_reset();
    ticks = 0; bad_an = 0; bad_sel = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (scan_tick) ticks++;
      if (an != 4'hF) bad_an++;
      if (digit_sel != 4'hE) bad_sel++;
    end
    check_eq("s6_ticks", ticks, 0);
    check_eq("s6_an_on", bad_an, 0);
    check_eq("s6_sel_moved", bad_sel, 0);

    // All digits masked: scanning continues, anodes stay off.
    digit_en = 4'h0;
    en = 1'b1;
    ticks = 0; bad_an = 0;
    for (int c = 0; c < 4 * DWELL + 1; c++) begin
      step(1);
      if (scan_tick) ticks++;
      if (an != 4'hF) bad_an++;
    end
    check_eq("mask0_ticks", ticks, 4);
    check_eq("mask0_an_on", bad_an, 0);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/anode_scan_ctrl.md
Name: anode_scan_ctrl

Overview:
Time-multiplexing controller for the 4-digit seven-segment display.
- Generates the active-low one-hot `digit_sel` code consumed by the switch-nibble mux (hex_num_gen_matrix) that selects which 4-bit value is shown.
- Generates the anode drive `an` for the board pins, with a per-digit dead-time blanking interval to suppress ghosting.
- Sits directly upstream of the nibble mux and the segment decoder.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- REFRESH_HZ, 1000, per-digit dwell rate. DWELL = CLK_HZ/REFRESH_HZ cycles per digit (integer division).
- BLANK_CYCLES, 1000, cycles at the start of each dwell during which all anodes are off.
  - Elaboration check: 1 <= BLANK_CYCLES < DWELL, DWELL >= 2.

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  scan enable. Synchronous; sampled on clk.
- digit_en  in  4  per-digit display mask; bit i=1 shows digit i.
- digit_sel  out  4  active-low one-hot digit select to the nibble mux. Always one of 1110/1101/1011/0111.
- an  out  4  active-low anode drive to the pins. 1111 = all off.
- digit_idx  out  2  binary index of the current digit (0 = rightmost, code 1110).
- scan_tick  out  1  one-cycle pulse in the cycle `digit_sel` advances.

Behaviour:
- All outputs are registered.
- Reset (async assert, any time, including mid-dwell):
  - digit_idx=0, digit_sel=1110, an=1111, scan_tick=0.
  - dwell counter cnt=0; state=BLANK if en else IDLE. On release, the next state is determined by en at the first edge.
- digit_sel is never 1111 and never multi-hot, in any state, including IDLE and during reset.
  - The downstream mux holds its previous value on invalid codes, so this is mandatory.
- digit_sel = ~(4'b0001 << digit_idx), always consistent with digit_idx in the same cycle.
- States:
  - IDLE: an=1111, cnt held at 0, digit_idx/digit_sel held, scan_tick=0. en=1 -> BLANK with cnt=0.
  - BLANK: an=1111. cnt increments each cycle. When cnt==BLANK_CYCLES-1 -> DRIVE.
  - DRIVE: an = digit_en[digit_idx] ? digit_sel : 1111. cnt increments. When cnt==DWELL-1:
    - cnt<=0;
    - digit_idx<=digit_idx+1 (wraps 3->0);
    - digit_sel updates in the same edge;
    - scan_tick=1 for that one cycle;
    - an<=1111;
    - state -> BLANK.
- an timing:
  - an reflects the state registered with it: an changes to 1111 on the same edge digit_sel advances.
  - A new digit's anode never turns on in the cycle its select changes.
- Dwell length:
  - BLANK_CYCLES cycles blank, then DWELL-BLANK_CYCLES cycles driven, per digit.
  - Full frame = 4*DWELL cycles.
- en deasserted in BLANK or DRIVE:
  - next edge -> IDLE, an=1111, cnt=0;
  - digit_idx is NOT advanced and scan_tick is not pulsed, even if cnt was DWELL-1.
  - Re-enable restarts the dwell of the same digit from BLANK.
- digit_en change mid-DRIVE: takes effect on the next edge (an follows the mask registered that cycle). No effect on timing or digit_sel.
- digit_en=0000: scanning and scan_tick continue normally; an stays 1111.
- Counter width: $clog2(DWELL). No overflow is possible, because cnt is bounded at DWELL-1.

Decomposition:
- Shared package (seg_disp_pkg):
  - NUM_DIGITS=4;
  - anode code constants AN_D0=4'b1110, AN_D1=4'b1101, AN_D2=4'b1011, AN_D3=4'b0111, AN_OFF=4'b1111;
  - state enum {IDLE, BLANK, DRIVE}.
- Sub-module scan_dwell_counter:
  - parameterised modulus DWELL and threshold BLANK_CYCLES;
  - inputs clk, reset, clr, inc;
  - outputs cnt, at_blank_end, at_dwell_end.
- FSM, index register and output registers stay in anode_scan_ctrl.

Test Plan:
Common bench parameters: CLK_HZ=100, REFRESH_HZ=10 (DWELL=10), BLANK_CYCLES=2.
1. Reset release with en=1, digit_en=1111 -> cycles 0-1 an=1111, cycles 2-9 an=1110. Edge 10: digit_sel=1101, digit_idx=1, an=1111, scan_tick=1 for one cycle. Cycles 12-19 an=1101.
2. Run 40+ cycles -> digit_sel sequence 1110,1101,1011,0111,1110. Wrap at cycle 40 with scan_tick pulse. Assert digit_sel is never 1111 or multi-hot, and an is never low while digit_sel changes.
3. digit_en=0101, one full frame -> an=1110 in digit-0 drive window and an=1011 in digit-2 drive window; an=1111 throughout digits 1 and 3. scan_tick count is still 4.
4. Drop en at cnt=9 of digit 1 -> an=1111, digit_idx stays 1, no scan_tick. Re-raise en 5 cycles later -> 2 blank cycles, then an=1101 for 8 cycles.
5. Assert reset asynchronously mid-DRIVE of digit 2 (between clock edges) -> an=1111, digit_sel=1110, digit_idx=0 immediately, without waiting for clk. After release, the timing of scenario 1 repeats exactly.
6. en=0 from reset -> an=1111, digit_sel=1110, scan_tick=0 for 100 cycles.
